// File: rtl/food_placer.sv
// Turns free-running pos_rng candidates into a legal food position by rejecting off-screen or
// snake-occupied spots. Optional retry cap is enabled by defining FOOD_RETRY_LIMIT_EN.
module food_placer #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned MAX_LEN  = 64,
  parameter int unsigned LEN_W    = 7
`ifdef FOOD_RETRY_LIMIT_EN
  ,
  parameter int unsigned MAX_TRIES = 255
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [7:0]       rng_posX,
  input  logic [6:0]       rng_posY,
  input  logic [LEN_W-1:0] snake_len,
  output logic [LEN_W-1:0] body_addr,
  input  logic [7:0]       body_x,
  input  logic [6:0]       body_y,
  output logic [7:0]       food_x,
  output logic [6:0]       food_y,
  output logic             food_valid,
  output logic             busy,
  output logic             done
`ifdef FOOD_RETRY_LIMIT_EN
  ,
  output logic             fail
`endif
);

  localparam logic [8:0]       XLim   = 9'(SCREEN_W);
  localparam logic [7:0]       YLim   = 8'(SCREEN_H);
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StSample, StScan, StDone} state_e;

  state_e           state_q;
  logic [7:0]       cand_x_q;
  logic [6:0]       cand_y_q;
  logic [LEN_W-1:0] idx_q;
  logic             cmp_valid_q;

  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] last_idx;
  logic             off_screen;
  logic             hit;
  logic             reject;

  always_comb begin
    len_eff    = (snake_len > MaxLen) ? MaxLen : snake_len;
    last_idx   = len_eff - LEN_W'(1);
    off_screen = ({1'b0, rng_posX} >= XLim) || ({1'b0, rng_posY} >= YLim);
    hit        = (body_x == cand_x_q) && (body_y == cand_y_q);
    reject     = ((state_q == StSample) && off_screen) ||
                 ((state_q == StScan) && cmp_valid_q && hit);
  end

  assign busy = (state_q != StIdle);

`ifdef FOOD_RETRY_LIMIT_EN
  localparam logic [7:0] TryCap = 8'(MAX_TRIES);
  logic [7:0] rej_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      idx_q       <= '0;
      cmp_valid_q <= 1'b0;
      body_addr   <= '0;
      food_x      <= '0;
      food_y      <= '0;
      food_valid  <= 1'b0;
      done        <= 1'b0;
`ifdef FOOD_RETRY_LIMIT_EN
      rej_cnt_q   <= '0;
      fail        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef FOOD_RETRY_LIMIT_EN
      fail <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (req) begin
            food_valid <= 1'b0;
`ifdef FOOD_RETRY_LIMIT_EN
            rej_cnt_q  <= '0;
`endif
            state_q    <= StSample;
          end
        end
        StSample: begin
          cand_x_q <= rng_posX;
          cand_y_q <= rng_posY;
          if (off_screen) begin
            state_q <= StSample;
          end else if (len_eff == '0) begin
            // Nothing to scan: publish straight from the sampled candidate
            food_x     <= rng_posX;
            food_y     <= rng_posY;
            food_valid <= 1'b1;
            done       <= 1'b1;
            state_q    <= StDone;
          end else begin
            body_addr   <= '0;
            idx_q       <= '0;
            cmp_valid_q <= 1'b0;
            state_q     <= StScan;
          end
        end
        StScan: begin
          // Read data lags the address by one cycle, so the first SCAN cycle has nothing to compare
          cmp_valid_q <= 1'b1;
          if (body_addr != last_idx) begin
            body_addr <= body_addr + LEN_W'(1);
          end
          if (cmp_valid_q) begin
            if (hit) begin
              state_q <= StSample;
            end else if (idx_q == last_idx) begin
              food_x     <= cand_x_q;
              food_y     <= cand_y_q;
              food_valid <= 1'b1;
              done       <= 1'b1;
              state_q    <= StDone;
            end else begin
              idx_q <= idx_q + LEN_W'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
`ifdef FOOD_RETRY_LIMIT_EN
      if (reject) begin
        rej_cnt_q <= rej_cnt_q + 8'd1;
        if (rej_cnt_q + 8'd1 == TryCap) begin
          fail    <= 1'b1;
          state_q <= StIdle;
        end
      end
`endif
    end
  end

`ifndef FOOD_RETRY_LIMIT_EN
  logic unused_reject;
  assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_food_placer.sv
// Self-checking bench for food_placer: vector table with a latency/position scoreboard plus
// hand-written reset-abort and retry-cap sequences.
module tb_food_placer;

  localparam int unsigned LEN_W = 7;

  logic             clk;
  logic             rst_n;
  logic             req;
  logic [7:0]       rng_posX;
  logic [6:0]       rng_posY;
  logic [LEN_W-1:0] snake_len;
  logic [LEN_W-1:0] body_addr;
  logic [7:0]       body_x;
  logic [6:0]       body_y;
  logic [7:0]       food_x;
  logic [6:0]       food_y;
  logic             food_valid;
  logic             busy;
  logic             done;
`ifdef FOOD_RETRY_LIMIT_EN
  logic             fail;
`endif

  food_placer #(
    .SCREEN_W (160),
    .SCREEN_H (120),
    .MAX_LEN  (64),
    .LEN_W    (LEN_W)
`ifdef FOOD_RETRY_LIMIT_EN
    ,
    .MAX_TRIES(4)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rng_posX  (rng_posX),
    .rng_posY  (rng_posY),
    .snake_len (snake_len),
    .body_addr (body_addr),
    .body_x    (body_x),
    .body_y    (body_y),
    .food_x    (food_x),
    .food_y    (food_y),
    .food_valid(food_valid),
    .busy      (busy),
    .done      (done)
`ifdef FOOD_RETRY_LIMIT_EN
    ,
    .fail      (fail)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Body memory with a one-cycle synchronous read
  logic [7:0] mem_x [128];
  logic [6:0] mem_y [128];
  always @(posedge clk) begin
    body_x <= mem_x[body_addr];
    body_y <= mem_y[body_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         len;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] x1;
    logic [6:0] y1;
    logic [7:0] ex;
    logic [6:0] ey;
    int         lat;
    bit         poke;
    bit         chk_addr;
  } vec_t;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    int         lat;
  } exp_t;

  exp_t sb[$];

  task automatic run_vec(input vec_t v, input int id);
    int   ndone;
    bit   got;
    exp_t e;
    snake_len = LEN_W'(v.len);
    rng_posX  = v.x0;
    rng_posY  = v.y0;
    req       = 1'b1;
    sb.push_back('{x: v.ex, y: v.ey, lat: v.lat});
    ndone = 0;
    got   = 1'b0;
    for (int cyc = 1; cyc <= 200 && !(got && cyc > v.lat + 4); cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        req = 1'b0;
        check($sformatf("v%0d_valid_cleared", id), 32'(food_valid), 32'd0);
        check($sformatf("v%0d_busy", id), 32'(busy), 32'd1);
      end
      if (cyc == 2) begin
        rng_posX = v.x1;
        rng_posY = v.y1;
      end
      if (v.poke) req = (cyc == 3);
      if (v.chk_addr && cyc >= 2 && cyc <= 4)
        check($sformatf("v%0d_addr_c%0d", id, cyc), 32'(body_addr), 32'(cyc - 2));
      if (done) begin
        ndone++;
        if (!got) begin
          got = 1'b1;
          e = sb.pop_front();
          check($sformatf("v%0d_lat", id), 32'(cyc), 32'(e.lat));
          check($sformatf("v%0d_x", id), 32'(food_x), 32'(e.x));
          check($sformatf("v%0d_y", id), 32'(food_y), 32'(e.y));
          check($sformatf("v%0d_valid", id), 32'(food_valid), 32'd1);
        end
      end
    end
    req = 1'b0;
    if (!got) begin
      check($sformatf("v%0d_timeout", id), 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    check($sformatf("v%0d_ndone", id), 32'(ndone), 32'd1);
    check($sformatf("v%0d_idle", id), 32'(busy), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem_x[i] = 8'(i);
      mem_y[i] = 7'd100;
    end
    mem_x[0] = 8'd5; mem_y[0] = 7'd5;
    mem_x[1] = 8'd6; mem_y[1] = 7'd5;
    mem_x[2] = 8'd7; mem_y[2] = 7'd5;
    // Entries past MAX_LEN collide with the candidate: only a clamped scan can finish
    for (int i = 64; i < 70; i++) begin
      mem_x[i] = 8'd100;
      mem_y[i] = 7'd100;
    end

    //        len  x0   y0   x1   y1   ex   ey   lat poke addr
    vecs[0] = '{0,  10,  20,  10,  20,  10,  20,  2,  0, 0};
    vecs[1] = '{3,  40,  30,  40,  30,  40,  30,  6,  0, 1};
    vecs[2] = '{3,  200, 30,  40,  30,  40,  30,  7,  0, 0};
    vecs[3] = '{3,  40,  120, 40,  30,  40,  30,  7,  0, 0};
    vecs[4] = '{3,  6,   5,   50,  60,  50,  60,  10, 1, 0};
    vecs[5] = '{3,  7,   5,   159, 119, 159, 119, 11, 0, 0};
    vecs[6] = '{3,  160, 0,   0,   0,   0,   0,   7,  0, 0};
    vecs[7] = '{70, 100, 100, 100, 100, 100, 100, 67, 0, 0};
    vecs[8] = '{1,  5,   5,   9,   9,   9,   9,   7,  0, 0};

    rst_n     = 1'b0;
    req       = 1'b0;
    rng_posX  = '0;
    rng_posY  = '0;
    snake_len = '0;
    repeat (3) @(negedge clk);
    check("rst_food_x", 32'(food_x), 32'd0);
    check("rst_food_y", 32'(food_y), 32'd0);
    check("rst_valid", 32'(food_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(body_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset asserted mid-SCAN aborts with everything cleared and no done afterwards
    begin
      int ndone;
      snake_len = LEN_W'(3);
      rng_posX  = 8'd40;
      rng_posY  = 7'd30;
      req       = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_scan_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mr_food_x", 32'(food_x), 32'd0);
      check("mr_food_y", 32'(food_y), 32'd0);
      check("mr_valid", 32'(food_valid), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_addr", 32'(body_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check("mr_no_done", 32'(ndone), 32'd0);
      check("mr_idle", 32'(busy), 32'd0);
    end

`ifdef FOOD_RETRY_LIMIT_EN
    // Four consecutive off-screen samples hit the cap of 4
    begin
      int fail_cyc;
      run_vec(vecs[0], 9);
      snake_len = '0;
      rng_posX  = 8'd170;
      rng_posY  = 7'd0;
      req       = 1'b1;
      fail_cyc  = -1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        @(negedge clk);
        req = 1'b0;
        if (fail && fail_cyc < 0) begin
          fail_cyc = cyc;
          check("cap_valid", 32'(food_valid), 32'd0);
          check("cap_busy", 32'(busy), 32'd0);
          check("cap_food_x", 32'(food_x), 32'd10);
        end
        if (done) check("cap_no_done", 32'(done), 32'd0);
      end
      check("cap_fail_cycle", 32'(fail_cyc), 32'd5);
      run_vec('{0, 3, 3, 3, 3, 3, 3, 2, 0, 0}, 10);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
